// File: rtl/sync_arith_unit_pkg.sv
// Shared op encoding and status-flag bit positions for the sync_arith_unit slice.
package sync_arith_unit_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SLT = 2'b10,
        OP_NEG = 2'b11
    } op_e;

    localparam int STATUS_W = 4;
    localparam int ST_ZERO  = 0;
    localparam int ST_NEG   = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_CARRY = 3;

endpackage

// File: rtl/sync_arith_unit_if.sv
// Operand/op bundle and next-state result/flags between the register stage and the ALU core.
interface sync_arith_unit_if
    import sync_arith_unit_pkg::*;
#(
    parameter int BITS = 32
) ();

    logic [BITS-1:0]     arg_a;
    logic [BITS-1:0]     arg_b;
    op_e                 op;
    logic [BITS-1:0]     nxt_result;
    logic [STATUS_W-1:0] nxt_status;

    modport master (
        output arg_a,
        output arg_b,
        output op,
        input  nxt_result,
        input  nxt_status
    );

    modport slave (
        input  arg_a,
        input  arg_b,
        input  op,
        output nxt_result,
        output nxt_status
    );

endinterface

// File: rtl/sync_arith_unit_comb.sv
// Purely combinational ALU core: next result and ZERO/NEG/OVF/CARRY flags.
// Zero latency, no handshake; the caller registers the outputs.
module arith_unit_comb
    import sync_arith_unit_pkg::*;
#(
    parameter int BITS = 32
) (
    sync_arith_unit_if.slave bus
);

    localparam int MSB = BITS - 1;
    localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

    logic [BITS:0]       w_sum;
    logic [BITS:0]       w_diff;
    logic [BITS-1:0]     w_neg;
    logic                w_lt;
    logic [BITS-1:0]     w_res;
    logic                w_ovf;
    logic                w_carry;
    logic [STATUS_W-1:0] w_status;

    assign w_sum  = {1'b0, bus.arg_a} + {1'b0, bus.arg_b};
    assign w_diff = {1'b0, bus.arg_a} - {1'b0, bus.arg_b};
    assign w_neg  = {BITS{1'b0}} - bus.arg_a;

    // Differing signs decide directly; equal signs reduce to the unsigned borrow.
    assign w_lt = (bus.arg_a[MSB] != bus.arg_b[MSB]) ? bus.arg_a[MSB] : w_diff[BITS];

    always_comb begin
        w_res   = '0;
        w_ovf   = 1'b0;
        w_carry = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[BITS];
                w_ovf   = (bus.arg_a[MSB] == bus.arg_b[MSB]) && (w_sum[MSB] != bus.arg_a[MSB]);
            end
            OP_SUB: begin
                w_res   = w_diff[MSB:0];
                w_carry = w_diff[BITS];
                w_ovf   = (bus.arg_a[MSB] != bus.arg_b[MSB]) && (w_diff[MSB] != bus.arg_a[MSB]);
            end
            OP_SLT: begin
                w_res = {{(BITS-1){1'b0}}, w_lt};
            end
            OP_NEG: begin
                w_res = w_neg;
                w_ovf = (bus.arg_a == MOST_NEG);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_status           = '0;
        w_status[ST_ZERO]  = ~|w_res;
        w_status[ST_NEG]   = w_res[MSB];
        w_status[ST_OVF]   = w_ovf;
        w_status[ST_CARRY] = w_carry;
    end

    assign bus.nxt_result = w_res;
    assign bus.nxt_status = w_status;

endmodule

// File: rtl/sync_arith_unit.sv
// Registered ALU: result and flags appear one cycle after the operands, one op per cycle.
// No backpressure; synchronous active-high reset clears both outputs.
module sync_arith_unit
    import sync_arith_unit_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [BITS-1:0]     i_arg_A,
    input  logic [BITS-1:0]     i_arg_B,
    input  logic [1:0]          i_op,
    output logic [BITS-1:0]     o_result,
    output logic [STATUS_W-1:0] o_status
);

    logic [BITS-1:0]     r_result;
    logic [STATUS_W-1:0] r_status;

    sync_arith_unit_if #(.BITS(BITS)) w_bus ();

    assign w_bus.arg_a = i_arg_A;
    assign w_bus.arg_b = i_arg_B;
    assign w_bus.op    = op_e'(i_op);

    arith_unit_comb #(.BITS(BITS)) u_comb (
        .bus (w_bus.slave)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_result <= '0;
            r_status <= '0;
        end else begin
            r_result <= w_bus.nxt_result;
            r_status <= w_bus.nxt_status;
        end
    end

    assign o_result = r_result;
    assign o_status = r_status;

endmodule

// File: tb/tb_sync_arith_unit.sv
// Directed table plus reset corner cases and a long random stream against an independent model.
module tb_sync_arith_unit;
    import sync_arith_unit_pkg::*;

    localparam int BITS = 32;
    localparam int NVEC = 16;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] o_result;
    logic [3:0]  o_status;
    int          total;
    int          bad;
    vec_t        vecs [NVEC];

    sync_arith_unit_if #(.BITS(BITS)) tb_bus ();

    sync_arith_unit #(.BITS(BITS)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_arg_A  (tb_bus.arg_a),
        .i_arg_B  (tb_bus.arg_b),
        .i_op     (tb_bus.op),
        .o_result (o_result),
        .o_status (o_status)
    );

    assign tb_bus.nxt_result = o_result;
    assign tb_bus.nxt_status = o_status;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_res, input logic [3:0] exp_st);
        total++;
        if (o_result !== exp_res || o_status !== exp_st) begin
            bad++;
            $display("FAIL %s: got result=%h status=%b, want result=%h status=%b",
                     name, o_result, o_status, exp_res, exp_st);
        end
    endtask

    // Reference computed with signed 64-bit range tests rather than carry bits.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] st);
        longint sa;
        longint sb;
        longint wide;
        logic   c;
        logic   o;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c  = 1'b0;
        o  = 1'b0;
        r  = '0;
        case (op)
            2'b00: begin
                r    = a + b;
                c    = (r < a);
                wide = sa + sb;
                o    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            2'b01: begin
                r    = a - b;
                c    = (a < b);
                wide = sa - sb;
                o    = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            2'b10: r = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                r = 32'd0 - a;
                o = (a == 32'h8000_0000);
            end
        endcase
        st = {c, o, r[31], (r == 32'd0)};
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        tb_bus.op    = op_e'(op);
        tb_bus.arg_a = a;
        tb_bus.arg_b = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] mr;
        logic [3:0]  ms;
        total = 0;
        bad   = 0;

        vecs[0]  = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001};
        vecs[2]  = '{2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b1010};
        vecs[3]  = '{2'b10, 32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 4'b0000};
        vecs[4]  = '{2'b11, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000, 4'b0110};
        vecs[5]  = '{2'b11, 32'h0000_0003, 32'h0000_0000, 32'hFFFF_FFFD, 4'b0010};
        vecs[6]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0100};
        vecs[7]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000};
        vecs[8]  = '{2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001};
        vecs[9]  = '{2'b10, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b0001};
        vecs[10] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0001};
        vecs[11] = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001};
        vecs[12] = '{2'b01, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b0001};
        vecs[13] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101};
        vecs[14] = '{2'b11, 32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0010};
        vecs[15] = '{2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1010};

        // Reset with non-trivial operands present must still clear the outputs.
        rst          = 1'b1;
        tb_bus.op    = OP_ADD;
        tb_bus.arg_a = 32'hFFFF_FFFF;
        tb_bus.arg_b = 32'h0000_0001;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 32'h0, 4'b0000);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_st);
        end

        // Outputs hold when operands change between edges.
        drive(2'b00, 32'h0000_0002, 32'h0000_0003);
        @(negedge clk);
        tb_bus.arg_a = 32'hDEAD_BEEF;
        tb_bus.op    = OP_NEG;
        #2;
        check("hold", 32'h0000_0005, 4'b0000);

        // One-cycle reset mid-stream discards that edge's operands, then resumes.
        @(negedge clk);
        rst          = 1'b1;
        tb_bus.op    = OP_SUB;
        tb_bus.arg_a = 32'h0000_0005;
        tb_bus.arg_b = 32'h0000_0007;
        @(posedge clk);
        #1;
        check("mid_reset", 32'h0, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset", 32'hFFFF_FFFE, 4'b1010);

        for (int n = 0; n < 1200; n++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic        do_rst;
            op     = 2'($urandom_range(0, 3));
            a      = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
            b      = ($urandom_range(0, 7) == 0) ? a : $urandom();
            do_rst = (n == 600);
            @(negedge clk);
            rst          = do_rst;
            tb_bus.op    = op_e'(op);
            tb_bus.arg_a = a;
            tb_bus.arg_b = b;
            @(posedge clk);
            #1;
            if (do_rst) begin
                mr = '0;
                ms = '0;
            end else begin
                model(op, a, b, mr, ms);
            end
            check($sformatf("rand%0d", n), mr, ms);
        end

        @(negedge clk);
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
